// File: rtl/piece_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tetris_pkg
// Brief    : Piece/state encodings and the 4x4-box shape table for every
//            tetromino and rotation.
// Revision : 1.0
// ============================================================================
package tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPAWN    = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_LOCK     = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam int         c_SPAWN_Y   = 0;
    localparam logic [1:0] c_SPAWN_ROT = 2'd0;

    // Each entry is {dx[1:0], dy[1:0]}; rotations are clockwise turns inside
    // a 4x4 box (I) or 3x3 box (T,S,Z,J,L). O is the same in all four.
    localparam logic [3:0] c_shape [7][4][4] = '{
        '{'{4'h1, 4'h5, 4'h9, 4'hD}, '{4'h8, 4'h9, 4'hA, 4'hB},
          '{4'hE, 4'hA, 4'h6, 4'h2}, '{4'h7, 4'h6, 4'h5, 4'h4}},
        '{'{4'h4, 4'h8, 4'h5, 4'h9}, '{4'h4, 4'h8, 4'h5, 4'h9},
          '{4'h4, 4'h8, 4'h5, 4'h9}, '{4'h4, 4'h8, 4'h5, 4'h9}},
        '{'{4'h1, 4'h5, 4'h9, 4'h6}, '{4'h4, 4'h5, 4'h6, 4'h1},
          '{4'h9, 4'h5, 4'h1, 4'h4}, '{4'h6, 4'h5, 4'h4, 4'h9}},
        '{'{4'h4, 4'h8, 4'h1, 4'h5}, '{4'h9, 4'hA, 4'h4, 4'h5},
          '{4'h6, 4'h2, 4'h9, 4'h5}, '{4'h1, 4'h0, 4'h6, 4'h5}},
        '{'{4'h0, 4'h4, 4'h5, 4'h9}, '{4'h8, 4'h9, 4'h5, 4'h6},
          '{4'hA, 4'h6, 4'h5, 4'h1}, '{4'h2, 4'h1, 4'h5, 4'h4}},
        '{'{4'h0, 4'h1, 4'h5, 4'h9}, '{4'h8, 4'h4, 4'h5, 4'h6},
          '{4'hA, 4'h9, 4'h5, 4'h1}, '{4'h2, 4'h6, 4'h5, 4'h4}},
        '{'{4'h8, 4'h1, 4'h5, 4'h9}, '{4'hA, 4'h4, 4'h5, 4'h6},
          '{4'h2, 4'h9, 4'h5, 4'h1}, '{4'h0, 4'h6, 4'h5, 4'h4}}
    };

    function automatic piece_t decode_piece(input logic [2:0] raw);
        return (raw == 3'd7) ? PIECE_I : piece_t'(raw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_controller_if.sv
`default_nettype none
// ============================================================================
// Interface : piece_controller_if
// Brief     : Game-control requests, board occupancy and piece outputs.
// Revision  : 1.0
// ============================================================================
interface piece_controller_if #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int XSIZE  = 3,
    parameter int YSIZE  = 3
);
    logic                          start;
    logic [2:0]                    piece_type;
    logic                          req_left;
    logic                          req_right;
    logic                          req_rot;
    logic                          req_down;
    logic [HEIGHT-1:0][WIDTH-1:0]  board;
    logic [3:0][XSIZE-1:0]         outX;
    logic [3:0][YSIZE-1:0]         outY;
    logic                          enable;
    logic                          lock;
    logic                          game_over;

    modport master (
        output start, piece_type, req_left, req_right, req_rot, req_down, board,
        input  outX, outY, enable, lock, game_over
    );

    modport slave (
        input  start, piece_type, req_left, req_right, req_rot, req_down, board,
        output outX, outY, enable, lock, game_over
    );
endinterface
`default_nettype wire

// File: rtl/piece_controller_fits.sv
`default_nettype none
// ============================================================================
// Module   : piece_fits
// Brief    : Resolves a piece pose to four cells and checks them against the
//            field bounds and locked-board occupancy.
// Revision : 1.0
// ============================================================================
module piece_fits
    import tetris_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int XSIZE  = 3,
    parameter int YSIZE  = 3
) (
    input  piece_t                        i_type,
    input  logic [1:0]                    i_rot,
    input  logic signed [XSIZE+1:0]       i_ox,
    input  logic signed [YSIZE+1:0]       i_oy,
    input  logic [HEIGHT-1:0][WIDTH-1:0]  i_board,
    output logic                          o_fits,
    output logic [3:0][XSIZE-1:0]         o_cx,
    output logic [3:0][YSIZE-1:0]         o_cy
);

    localparam logic signed [XSIZE+1:0] c_XLIM = (XSIZE+2)'(WIDTH);
    localparam logic signed [YSIZE+1:0] c_YLIM = (YSIZE+2)'(HEIGHT);

    logic [3:0] w_ok;

    for (genvar i = 0; i < 4; i++) begin : g_cell
        logic [3:0]              w_off;
        logic signed [XSIZE+1:0] w_x;
        logic signed [YSIZE+1:0] w_y;
        logic                    w_in;

        assign w_off = c_shape[i_type][i_rot][i];
        assign w_x   = i_ox + $signed({{XSIZE{1'b0}}, w_off[3:2]});
        assign w_y   = i_oy + $signed({{YSIZE{1'b0}}, w_off[1:0]});

        // Full signed range checked first so a negative column never aliases
        // onto the right edge after truncation.
        assign w_in    = !w_x[XSIZE+1] && (w_x < c_XLIM) &&
                         !w_y[YSIZE+1] && (w_y < c_YLIM);
        assign w_ok[i] = w_in && !i_board[w_y[YSIZE-1:0]][w_x[XSIZE-1:0]];
        assign o_cx[i] = w_x[XSIZE-1:0];
        assign o_cy[i] = w_y[YSIZE-1:0];
    end

    assign o_fits = &w_ok;

endmodule
`default_nettype wire

// File: rtl/piece_controller.sv
`default_nettype none
// ============================================================================
// Module   : piece_controller
// Brief    : Owns the falling tetromino; validates move/rotate/gravity
//            requests and pulses lock when the piece comes to rest.
// Revision : 1.0
// ============================================================================
module piece_controller
    import tetris_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int XSIZE   = 3,
    parameter int YSIZE   = 3,
    parameter int SPAWN_X = 2
) (
    input  logic               clk,
    input  logic               reset,
    piece_controller_if.slave  bus
);

    localparam logic signed [XSIZE+1:0] c_SPAWN_OX = (XSIZE+2)'(SPAWN_X);
    localparam logic signed [YSIZE+1:0] c_SPAWN_OY = (YSIZE+2)'(c_SPAWN_Y);
    localparam logic signed [XSIZE+1:0] c_ONE_X    = (XSIZE+2)'(1);
    localparam logic signed [YSIZE+1:0] c_ONE_Y    = (YSIZE+2)'(1);

    state_t                  r_state, w_state_nxt;
    piece_t                  r_type, w_type_nxt;
    logic [1:0]              r_rot, w_rot_nxt;
    logic signed [XSIZE+1:0] r_ox, w_ox_nxt;
    logic signed [YSIZE+1:0] r_oy, w_oy_nxt;

    piece_t                  w_spawn_type;
    piece_t                  w_cand_type;
    logic [1:0]              w_cand_rot;
    logic signed [XSIZE+1:0] w_cand_ox;
    logic signed [YSIZE+1:0] w_cand_oy;
    logic                    w_cand_fits;
    logic                    w_has_req;
    logic                    w_is_down;

    logic [3:0][XSIZE-1:0]   w_cand_cx, w_cur_cx;
    logic [3:0][YSIZE-1:0]   w_cand_cy, w_cur_cy;
    logic                    w_unused_cur_fits;
    logic                    w_enable;
    logic                    w_unused_cand_cells;

    assign w_spawn_type = decode_piece(bus.piece_type);

    // Candidate pose: the spawn pose in SPAWN, otherwise the single
    // highest-priority request applied to the current pose.
    always_comb begin
        w_cand_type = r_type;
        w_cand_rot  = r_rot;
        w_cand_ox   = r_ox;
        w_cand_oy   = r_oy;
        w_has_req   = 1'b0;
        w_is_down   = 1'b0;
        if (r_state == ST_SPAWN) begin
            w_cand_type = w_spawn_type;
            w_cand_rot  = c_SPAWN_ROT;
            w_cand_ox   = c_SPAWN_OX;
            w_cand_oy   = c_SPAWN_OY;
        end else if (r_state == ST_ACTIVE) begin
            w_has_req = 1'b1;
            if (bus.req_rot) begin
                w_cand_rot = r_rot + 2'd1;
            end else if (bus.req_left) begin
                w_cand_ox = r_ox - c_ONE_X;
            end else if (bus.req_right) begin
                w_cand_ox = r_ox + c_ONE_X;
            end else if (bus.req_down) begin
                w_cand_oy = r_oy + c_ONE_Y;
                w_is_down = 1'b1;
            end else begin
                w_has_req = 1'b0;
            end
        end
    end

    piece_fits #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XSIZE  (XSIZE),
        .YSIZE  (YSIZE)
    ) u_cand_fits (
        .i_type  (w_cand_type),
        .i_rot   (w_cand_rot),
        .i_ox    (w_cand_ox),
        .i_oy    (w_cand_oy),
        .i_board (bus.board),
        .o_fits  (w_cand_fits),
        .o_cx    (w_cand_cx),
        .o_cy    (w_cand_cy)
    );

    piece_fits #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XSIZE  (XSIZE),
        .YSIZE  (YSIZE)
    ) u_cur_fits (
        .i_type  (r_type),
        .i_rot   (r_rot),
        .i_ox    (r_ox),
        .i_oy    (r_oy),
        .i_board (bus.board),
        .o_fits  (w_unused_cur_fits),
        .o_cx    (w_cur_cx),
        .o_cy    (w_cur_cy)
    );

    assign w_unused_cand_cells = ^{w_cand_cx, w_cand_cy};

    always_comb begin
        w_state_nxt = r_state;
        w_type_nxt  = r_type;
        w_rot_nxt   = r_rot;
        w_ox_nxt    = r_ox;
        w_oy_nxt    = r_oy;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_SPAWN;
            end
            ST_SPAWN: begin
                w_type_nxt  = w_cand_type;
                w_rot_nxt   = w_cand_rot;
                w_ox_nxt    = w_cand_ox;
                w_oy_nxt    = w_cand_oy;
                w_state_nxt = w_cand_fits ? ST_ACTIVE : ST_GAMEOVER;
            end
            ST_ACTIVE: begin
                if (w_has_req) begin
                    if (w_cand_fits) begin
                        w_rot_nxt = w_cand_rot;
                        w_ox_nxt  = w_cand_ox;
                        w_oy_nxt  = w_cand_oy;
                    end else if (w_is_down) begin
                        w_state_nxt = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                w_state_nxt = ST_SPAWN;
            end
            ST_GAMEOVER: begin
                if (bus.start) w_state_nxt = ST_SPAWN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_type  <= PIECE_I;
            r_rot   <= 2'd0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_type  <= w_type_nxt;
            r_rot   <= w_rot_nxt;
            r_ox    <= w_ox_nxt;
            r_oy    <= w_oy_nxt;
        end
    end

    assign w_enable      = (r_state == ST_ACTIVE) || (r_state == ST_LOCK);
    assign bus.enable    = w_enable;
    // The board writer samples lock on the same edge that applies reset.
    assign bus.lock      = (r_state == ST_LOCK) && !reset;
    assign bus.game_over = (r_state == ST_GAMEOVER);
    assign bus.outX      = w_enable ? w_cur_cx : '0;
    assign bus.outY      = w_enable ? w_cur_cy : '0;

endmodule
`default_nettype wire

// File: doc/piece_controller.md
Name: piece_controller

Overview:
- Upstream of the piece-to-matrix renderer.
- Owns the falling tetromino: type, rotation and origin on the 8x8 field.
- Validates move, rotate and gravity requests against field bounds and the locked-board occupancy matrix.
- Outputs the four cell coordinates plus a display enable, and pulses lock when the piece comes to rest so the board register can absorb it.

Parameters:
- WIDTH, 8, field columns
- HEIGHT, 8, field rows
- XSIZE, 3, column-index bits (clog2 WIDTH)
- YSIZE, 3, row-index bits (clog2 HEIGHT)
- SPAWN_X, 2, origin column of a newly spawned piece

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a game from IDLE or GAMEOVER
- piece_type  in  3  next piece, 0..6 = I,O,T,S,Z,J,L; values 7 treated as 0; sampled in SPAWN
- req_left  in  1  shift left one column
- req_right  in  1  shift right one column
- req_rot  in  1  rotate clockwise
- req_down  in  1  soft drop, or gravity tick, one row
- board  in  HEIGHT x WIDTH  locked-cell occupancy, [row][col], row 0 = top
- outX  out  4 x XSIZE  cell columns of current piece
- outY  out  4 x YSIZE  cell rows of current piece
- enable  out  1  cells valid/displayable
- lock  out  1  one-cycle pulse: piece at rest, write cells into board
- game_over  out  1  spawn collided; level until start

Behaviour:
- Reset: all outputs 0; state IDLE; origin (0,0); rotation 0; type 0.
- State machine:
  - IDLE: start -> SPAWN.
  - SPAWN, one cycle: latch piece_type; rotation=0; origin=(SPAWN_X,0). If any spawn cell is occupied in board -> GAMEOVER, else -> ACTIVE.
  - ACTIVE:
    - Evaluate at most one request per cycle; priority rot > left > right > down. Lower-priority requests that cycle are discarded, not queued.
    - Candidate = current state with the change applied.
    - Accept iff all 4 candidate cells satisfy 0<=cx<WIDTH, 0<=cy<HEIGHT, and board[cy][cx]==0.
    - Accepted change is registered; outputs reflect it the next cycle (latency 1).
    - Rejected rot/left/right: no change.
    - Rejected down -> LOCK.
    - No wall kicks.
  - LOCK, one cycle: lock=1, enable=1, outX/outY hold the resting cells -> SPAWN. The board writer registers on lock, so SPAWN sees the updated board.
  - GAMEOVER: game_over=1, enable=0; start -> SPAWN with game_over cleared that cycle.
- enable=1 in ACTIVE and LOCK only; 0 in IDLE, SPAWN and GAMEOVER.
- Origin arithmetic:
  - Origin is signed, XSIZE+2 / YSIZE+2 bits; range -2..WIDTH-1.
  - Cell = origin + shape offset. Offsets are unsigned 0..3 within a 4x4 box, so edge columns stay reachable.
  - Bounds are compared at full signed width before truncating to outX/outY. No wrap-around is permitted.
- Requests in IDLE, SPAWN, LOCK and GAMEOVER are ignored.
- Reset mid-ACTIVE or mid-LOCK: return to IDLE; lock is never emitted on the reset cycle.
- O piece: all 4 rotations identical; rotate is always accepted if the current position is legal.

Decomposition:
- Package tetris_pkg:
  - piece_t enum (I,O,T,S,Z,J,L)
  - state_t enum (IDLE,SPAWN,ACTIVE,LOCK,GAMEOVER)
  - SHAPE constant [7][4][4] of {dx,dy} 2-bit offsets
  - spawn constants
- Sub-module piece_fits: combinational; inputs type, rotation, origin, board; outputs fits plus the 4 cell coordinates.
  - Instantiated twice: once for the candidate, once for the current position that drives outputs.

Test Plan:
- Reset then start, piece_type=T, empty board:
  - SPAWN then ACTIVE, enable=1.
  - Cells {(2,1),(3,1),(4,1),(3,2)} per the package table.
  - Check layout against SHAPE.
- O piece at the left wall:
  - Repeated req_left stops at min column 0; one further req_left leaves outX unchanged.
  - Symmetric test at column 7.
- req_rot and req_left asserted the same cycle:
  - Only the rotation applies.
  - Next cycle shows the rotated cells at the unchanged origin.
- I piece (vertical) dropped on an empty board:
  - req_down held every cycle until the bottom cell reaches row 7.
  - Next req_down -> lock pulses exactly 1 cycle with outY max=7, then SPAWN.
- Board row 1 fully occupied, then spawn:
  - Spawn cells collide -> game_over=1, enable=0.
  - Requests ignored.
  - start -> SPAWN; game_over cleared.
- Reset asserted in the LOCK cycle:
  - Next cycle: state IDLE, all outputs 0, no lock pulse observed after reset.
